// File: rtl/gshare_pht.sv
// gshare pattern history table: 2-bit counters indexed by pc ^ gbhr, with an
// in-order in-flight queue so resolves update the entry that made the prediction.
module gshare_pht #(
    parameter int W_PHT   = 4,
    parameter int W_PC    = 8,
    parameter int DEPTH_Q = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             EN,
    input  logic             predict,
    input  logic [W_PC-1:0]  pc,
    input  logic [W_PHT-1:0] gbhr,
    input  logic             resolve,
    input  logic             actual_taken,
    output logic             pred_valid,
    output logic             pred_taken,
    output logic             mispredict,
    output logic             resolve_err,
    output logic             q_full,
    output logic             q_empty
);
    localparam int N_ENT = 1 << W_PHT;
    localparam int W_Q   = $clog2(DEPTH_Q);
    localparam logic [W_Q:0] Q_FULL = (W_Q+1)'(DEPTH_Q);

    typedef struct packed {
        logic [W_PHT-1:0] idx;
        logic             pred;
    } q_ent_t;

    logic [1:0]   cnt_q [N_ENT];
    logic [1:0]   cnt_d [N_ENT];
    q_ent_t       q_q   [DEPTH_Q];
    q_ent_t       q_d   [DEPTH_Q];
    logic [W_Q-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
    logic [W_Q:0]   count_q, count_d;
    logic pred_valid_q, pred_valid_d, pred_taken_q, pred_taken_d;
    logic mispredict_q, mispredict_d, resolve_err_q, resolve_err_d;

    logic [W_PHT-1:0] idx;
    logic             push, pop;
    q_ent_t           head;

    assign q_full  = (count_q == Q_FULL);
    assign q_empty = (count_q == '0);

    always_comb begin
        idx  = pc[W_PHT-1:0] ^ gbhr;
        push = EN & predict & ~q_full;
        pop  = EN & resolve & ~q_empty;
        head = q_q[rptr_q];

        cnt_d   = cnt_q;
        q_d     = q_q;
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;

        pred_valid_d  = push;
        // Reads pre-update counters even when a resolve hits the same index.
        pred_taken_d  = push ? cnt_q[idx][1] : pred_taken_q;
        mispredict_d  = pop & (head.pred != actual_taken);
        resolve_err_d = EN & resolve & q_empty;

        if (push) begin
            q_d[wptr_q] = '{idx: idx, pred: cnt_q[idx][1]};
            wptr_d      = wptr_q + 1'b1;
        end
        if (pop) begin
            rptr_d = rptr_q + 1'b1;
            if (actual_taken && cnt_q[head.idx] != 2'b11)
                cnt_d[head.idx] = cnt_q[head.idx] + 2'b01;
            else if (!actual_taken && cnt_q[head.idx] != 2'b00)
                cnt_d[head.idx] = cnt_q[head.idx] - 2'b01;
        end
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < N_ENT; i++) cnt_q[i] <= 2'b01;
            for (int i = 0; i < DEPTH_Q; i++) q_q[i] <= '0;
            wptr_q        <= '0;
            rptr_q        <= '0;
            count_q       <= '0;
            pred_valid_q  <= 1'b0;
            pred_taken_q  <= 1'b0;
            mispredict_q  <= 1'b0;
            resolve_err_q <= 1'b0;
        end else begin
            cnt_q         <= cnt_d;
            q_q           <= q_d;
            wptr_q        <= wptr_d;
            rptr_q        <= rptr_d;
            count_q       <= count_d;
            pred_valid_q  <= pred_valid_d;
            pred_taken_q  <= pred_taken_d;
            mispredict_q  <= mispredict_d;
            resolve_err_q <= resolve_err_d;
        end
    end

    assign pred_valid  = pred_valid_q;
    assign pred_taken  = pred_taken_q;
    assign mispredict  = mispredict_q;
    assign resolve_err = resolve_err_q;
endmodule

// File: tb/tb_gshare_pht.sv
// Directed bench for gshare_pht with hand-computed expectations.
module tb_gshare_pht;
    logic       clk = 1'b0, rst = 1'b1, EN = 1'b1;
    logic       predict = 1'b0, resolve = 1'b0, actual_taken = 1'b0;
    logic [7:0] pc = '0;
    logic [3:0] gbhr = '0;
    logic       pred_valid, pred_taken, mispredict, resolve_err, q_full, q_empty;
    int         checks = 0, errors = 0;
    logic [1:0] exp_cnt [16];

    gshare_pht #(.W_PHT(4), .W_PC(8), .DEPTH_Q(4)) dut (
        .clk(clk), .rst(rst), .EN(EN), .predict(predict), .pc(pc), .gbhr(gbhr),
        .resolve(resolve), .actual_taken(actual_taken), .pred_valid(pred_valid),
        .pred_taken(pred_taken), .mispredict(mispredict), .resolve_err(resolve_err),
        .q_full(q_full), .q_empty(q_empty)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle;
        predict = 1'b0; resolve = 1'b0; actual_taken = 1'b0;
    endtask

    // Drive one cycle, then check the registered pulses it produced.
    task automatic cyc(input logic p, input logic [7:0] p_pc, input logic [3:0] g,
                       input logic r, input logic at, input string tag,
                       input logic e_pv, input logic e_pt, input logic e_mp,
                       input logic e_re, input logic e_full, input logic e_empty);
        predict = p; pc = p_pc; gbhr = g; resolve = r; actual_taken = at;
        tick();
        idle();
        checks++;
        if ({pred_valid, pred_taken, mispredict, resolve_err, q_full, q_empty} !==
            {e_pv, e_pt, e_mp, e_re, e_full, e_empty}) begin
            errors++;
            $display("FAIL %s pv/pt/mp/re/full/empty got %b%b%b%b%b%b exp %b%b%b%b%b%b", tag,
                     pred_valid, pred_taken, mispredict, resolve_err, q_full, q_empty,
                     e_pv, e_pt, e_mp, e_re, e_full, e_empty);
        end
    endtask

    task automatic check_table(input string tag);
        checks++;
        for (int i = 0; i < 16; i++) begin
            if (dut.cnt_q[i] !== exp_cnt[i]) begin
                errors++;
                $display("FAIL %s cnt[%0d] got %b exp %b", tag, i, dut.cnt_q[i], exp_cnt[i]);
                break;
            end
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        tick();
        for (int i = 0; i < 16; i++) exp_cnt[i] = 2'b01;
        checks++;
        if ({pred_valid, pred_taken, mispredict, resolve_err, q_full, q_empty} !== 6'b000001) begin
            errors++;
            $display("FAIL reset_outputs got %b exp 000001",
                     {pred_valid, pred_taken, mispredict, resolve_err, q_full, q_empty});
        end
        check_table("reset_table");
        rst = 1'b0;
        tick();
    endtask

    task automatic test_basic;
        cyc(1, 8'h05, 4'h0, 0, 0, "basic_pred0", 1, 0, 0, 0, 0, 0);
        cyc(0, 8'h00, 4'h0, 1, 1, "basic_res",   0, 0, 1, 0, 0, 1);
        exp_cnt[5] = 2'b10;
        check_table("basic_cnt5");
        cyc(1, 8'h05, 4'h0, 0, 0, "basic_pred1", 1, 1, 0, 0, 0, 0);
        // pred_taken holds while pred_valid is low
        cyc(0, 8'h00, 4'h0, 0, 0, "basic_hold",  0, 1, 0, 0, 0, 0);
        cyc(0, 8'h00, 4'h0, 1, 1, "basic_res2",  0, 1, 0, 0, 0, 1);
        exp_cnt[5] = 2'b11;
        check_table("basic_cnt5b");
    endtask

    task automatic test_saturation;
        cyc(1, 8'h01, 4'h2, 0, 0, "sat_p1", 1, 0, 0, 0, 0, 0);
        cyc(0, 8'h00, 4'h0, 1, 1, "sat_r1", 0, 0, 1, 0, 0, 1);
        cyc(1, 8'h01, 4'h2, 0, 0, "sat_p2", 1, 1, 0, 0, 0, 0);
        cyc(0, 8'h00, 4'h0, 1, 1, "sat_r2", 0, 1, 0, 0, 0, 1);
        cyc(1, 8'h01, 4'h2, 0, 0, "sat_p3", 1, 1, 0, 0, 0, 0);
        cyc(0, 8'h00, 4'h0, 1, 1, "sat_r3", 0, 1, 0, 0, 0, 1);
        exp_cnt[3] = 2'b11;
        check_table("sat_cnt3_11");
        cyc(1, 8'h01, 4'h2, 0, 0, "sat_p4", 1, 1, 0, 0, 0, 0);
        cyc(0, 8'h00, 4'h0, 1, 0, "sat_nt", 0, 1, 1, 0, 0, 1);
        exp_cnt[3] = 2'b10;
        check_table("sat_cnt3_10");
        cyc(1, 8'h01, 4'h2, 0, 0, "sat_p5", 1, 1, 0, 0, 0, 0);
        cyc(0, 8'h00, 4'h0, 1, 1, "sat_r5", 0, 1, 0, 0, 0, 1);
        exp_cnt[3] = 2'b11;
    endtask

    task automatic test_queue_full;
        cyc(1, 8'h01, 4'h0, 0, 0, "qf_p1", 1, 0, 0, 0, 0, 0);
        cyc(1, 8'h02, 4'h0, 0, 0, "qf_p2", 1, 0, 0, 0, 0, 0);
        cyc(1, 8'h03, 4'h0, 0, 0, "qf_p3", 1, 1, 0, 0, 0, 0);
        cyc(1, 8'h04, 4'h0, 0, 0, "qf_p4", 1, 0, 0, 0, 1, 0);
        cyc(1, 8'h07, 4'h0, 0, 0, "qf_p5", 0, 0, 0, 0, 1, 0);
        // Predict alongside a pop while full is still rejected
        cyc(1, 8'h07, 4'h0, 1, 1, "qf_r1", 0, 0, 1, 0, 0, 0);
        exp_cnt[1] = 2'b10;
        check_table("qf_cnt1");
        cyc(0, 8'h00, 4'h0, 1, 1, "qf_r2", 0, 0, 1, 0, 0, 0);
        exp_cnt[2] = 2'b10;
        check_table("qf_cnt2");
        cyc(0, 8'h00, 4'h0, 1, 1, "qf_r3", 0, 0, 0, 0, 0, 0);
        check_table("qf_cnt3");
        cyc(0, 8'h00, 4'h0, 1, 1, "qf_r4", 0, 0, 1, 0, 0, 1);
        exp_cnt[4] = 2'b10;
        check_table("qf_cnt4");
    endtask

    task automatic test_empty_resolve;
        cyc(0, 8'h00, 4'h0, 1, 1, "er_res",  0, 0, 0, 1, 0, 1);
        check_table("er_table");
        cyc(0, 8'h00, 4'h0, 0, 0, "er_idle", 0, 0, 0, 0, 0, 1);
    endtask

    task automatic test_enable;
        cyc(1, 8'h05, 4'h0, 0, 0, "en_push", 1, 1, 0, 0, 0, 0);
        EN = 1'b0;
        cyc(1, 8'h01, 4'h0, 1, 0, "en_off",  0, 1, 0, 0, 0, 0);
        check_table("en_table");
        EN = 1'b1;
        cyc(0, 8'h00, 4'h0, 1, 1, "en_pop",  0, 1, 0, 0, 0, 1);
    endtask

    task automatic test_back_to_back;
        cyc(1, 8'h06, 4'h0, 0, 0, "b2b_p",  1, 0, 0, 0, 0, 0);
        cyc(1, 8'h06, 4'h0, 1, 1, "b2b_pr", 1, 0, 1, 0, 0, 0);
        exp_cnt[6] = 2'b10;
        check_table("b2b_cnt6");
        rst = 1'b1;
        #1;
        exp_cnt[6] = 2'b01;
        checks++;
        if ({pred_valid, pred_taken, mispredict, resolve_err, q_full, q_empty} !== 6'b000001) begin
            errors++;
            $display("FAIL mid_reset got %b exp 000001",
                     {pred_valid, pred_taken, mispredict, resolve_err, q_full, q_empty});
        end
        exp_cnt[5] = 2'b01; exp_cnt[3] = 2'b01; exp_cnt[1] = 2'b01;
        exp_cnt[2] = 2'b01; exp_cnt[4] = 2'b01;
        check_table("mid_reset_table");
        tick();
        rst = 1'b0;
        tick();
        cyc(0, 8'h00, 4'h0, 1, 1, "post_reset_res", 0, 0, 0, 1, 0, 1);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_saturation();
        test_queue_full();
        test_empty_resolve();
        test_enable();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/gshare_pht.md
Name: gshare_pht

Overview:
Pattern history table that consumes the global branch history register (GBHR) value and produces branch predictions using the gshare scheme.
- Index is the low PC bits XOR the GBHR.
- Each entry is a 2-bit saturating counter.
- An in-order in-flight queue records each prediction's index and predicted direction, so that a later resolve updates the correct entry and flags mispredicts.
- Sits beside the GBHR: both see the same predict/resolve strobes.

Parameters:
W_PHT, 4, history width and PHT index width; table holds 2^W_PHT counters
W_PC, 8, branch PC width; W_PC >= W_PHT
DEPTH_Q, 4, in-flight prediction queue depth; power of two >= 2

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  asynchronous reset, active-high
EN  input  1  global enable; when 0 all state holds and pulse outputs are 0
predict  input  1  prediction request this cycle
pc  input  W_PC  branch PC for the request
gbhr  input  W_PHT  current global history from GBHR
resolve  input  1  oldest in-flight branch resolves this cycle
actual_taken  input  1  resolved outcome, 1 = taken
pred_valid  output  1  one-cycle pulse, prediction response valid
pred_taken  output  1  predicted direction, meaningful when pred_valid=1
mispredict  output  1  one-cycle pulse, resolved outcome differs from stored prediction
resolve_err  output  1  one-cycle pulse, resolve arrived with empty queue
q_full  output  1  queue holds DEPTH_Q entries
q_empty  output  1  queue holds 0 entries

Behaviour:
- Reset (async, rst=1):
  - all counters = 2'b01 (weakly not-taken);
  - queue empty, so q_empty=1 and q_full=0;
  - pred_valid, pred_taken, mispredict and resolve_err = 0.
  - Reset mid-operation discards all in-flight entries.
- Index: idx = pc[W_PHT-1:0] ^ gbhr.
- Predict accept: EN & predict & !q_full, where q_full is the start-of-cycle value.
  - On the next edge: pred_valid=1 and pred_taken=counter[idx][1]. Latency is 1 cycle.
  - {idx, pred bit} is pushed at the queue tail.
- Predict when q_full=1: ignored; pred_valid stays 0; no push. This holds even if a resolve pops in the same cycle.
- Resolve accept: EN & resolve & !q_empty, where q_empty is the start-of-cycle value.
  - Pops the head entry {hidx, hpred}.
  - Counter update on the same edge: taken increments, saturating at 2'b11; not-taken decrements, saturating at 2'b00.
  - mispredict = (hpred != actual_taken), registered, visible the next cycle for 1 cycle.
- Resolve when q_empty=1: no pop, no counter change; resolve_err=1 for 1 cycle.
- Simultaneous accepted predict and resolve:
  - push and pop both occur; occupancy is unchanged.
  - If idx == hidx, the prediction reads the pre-update counter value (no bypass).
- Pulse outputs deassert the cycle after assertion unless re-triggered.
- pred_taken holds its last value when pred_valid=0.
- EN=0: predict and resolve are ignored; all pulses are 0 the next cycle; counters and queue hold.
- Queue:
  - circular buffer with W_Q=log2(DEPTH_Q) pointers that wrap modulo DEPTH_Q;
  - occupancy counter of W_Q+1 bits;
  - q_full = (count == DEPTH_Q), q_empty = (count == 0), both combinational from registered count.
- The GBHR shift on predict/resolve is owned by the GBHR block. This block only samples gbhr when a predict is accepted.

Test Plan:
- Reset, then predict pc=8'h05, gbhr=4'b0000 -> idx 5. Next cycle pred_valid=1, pred_taken=0, q_empty=0.
- Resolve actual_taken=1 -> counter[5] goes 01->10; mispredict=1 next cycle. Then predict pc=8'h05, gbhr=0 -> pred_taken=1.
- Saturation at idx 3 (pc=8'h01, gbhr=4'b0010):
  - three predict+resolve-taken pairs -> counter 01->10->11->11; third pred_taken=1, mispredict=0;
  - one resolve not-taken -> counter 10, mispredict=1, next prediction still taken.
- Queue full:
  - four predicts with idx 1, 2, 3, 4 and no resolve -> q_full=1;
  - fifth predict gives pred_valid=0;
  - four resolves pop idx 1, 2, 3, 4 in order (check counters), after which q_empty=1.
- Empty resolve: resolve=1 with q_empty=1 -> resolve_err=1 for one cycle; all counters unchanged; mispredict=0.
- One entry queued at idx 6 (counter 01), then predict idx 6 and resolve taken in the same cycle:
  - pred_taken=0 (pre-update read); counter[6]=10; occupancy stays 1.
  - Then assert rst mid-stream -> queue empty, counter[6]=01, all outputs 0 immediately.
